// File: rtl/streamwriter.sv
// streamwriter
// ------------
// Packs variable-width element writes into fixed OBYTES-wide output beats.
// Each of the IOPT option ports writes W_k = BASEB << k bytes per accepted
// transfer. The bytes are appended, with no gaps, to an internal packing
// buffer. Whenever a full beat is buffered it is offered downstream. A flush
// request drains any trailing partial beat, zero-padded, and then pulses fdone.
//
// Ports
//   clk     clock; all state changes on the rising edge
//   rst     synchronous reset, active low
//   ivalid  per-option write valid
//   iready  per-option write accept (only the lowest valid option can win)
//   idata   write data; option k uses bytes 0..W_k-1
//   flush   request to drain partial data (level, sampled while fready=1)
//   fready  flush can be accepted this cycle
//   fdone   one-cycle pulse: flush complete, buffer empty
//   ovalid  output beat valid
//   oready  downstream accepts the beat
//   odata   beat data, byte 0 = oldest; bytes at index >= obytes are zero
//   obytes  number of valid bytes in the beat (0 when ovalid=0)
//
// Parameter constraints: IBYTES == BASEB << (IOPT-1), OBYTES >= IBYTES,
// BUFB >= OBYTES.
module streamwriter #(
  parameter int IOPT   = 4,
  parameter int BASEB  = 8,
  parameter int IBYTES = 64,
  parameter int OBYTES = 64,
  parameter int BUFB   = 2 * OBYTES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IOPT-1:0]               ivalid,
  output logic [IOPT-1:0]               iready,
  input  logic [IBYTES-1:0][7:0]        idata,
  input  logic                          flush,
  output logic                          fready,
  output logic                          fdone,
  output logic                          ovalid,
  input  logic                          oready,
  output logic [OBYTES-1:0][7:0]        odata,
  output logic [$clog2(OBYTES+1)-1:0]   obytes
);

  // The count must hold cnt + W_k before the fit test, so it is sized for
  // BUFB + IBYTES.
  localparam int CW   = $clog2(BUFB + IBYTES + 1);
  localparam int OBW  = $clog2(OBYTES + 1);
  localparam int AW   = (BUFB > 1) ? $clog2(BUFB) : 1;
  localparam int IW   = (IBYTES > 1) ? $clog2(IBYTES) : 1;
  localparam int SELW = (IOPT > 1) ? $clog2(IOPT) : 1;

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [CW-1:0]            cnt_reg, cnt_next;
  logic [BUFB-1:0][7:0]     buf_reg, buf_next;

  logic [SELW-1:0]          sel;
  logic                     any_valid;
  logic                     in_fire;
  logic                     out_fire;
  logic                     ovalid_int;
  logic [OBW-1:0]           obytes_int;
  logic [CW-1:0]            w_sel;
  logic [CW-1:0]            drained;
  logic [CW-1:0]            base;

  // Priority select: the lowest-numbered valid option is the only candidate.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    for (int k = IOPT - 1; k >= 0; k--) begin
      if (ivalid[k]) begin
        sel       = SELW'(k);
        any_valid = 1'b1;
      end
    end
  end

  // Acceptance looks only at the current count, never at this cycle's drain,
  // so there is no combinational path from oready to iready. Both iready and
  // ovalid are held low while reset is asserted.
  genvar gi;
  generate
    for (gi = 0; gi < IOPT; gi++) begin : g_opt
      localparam logic [CW-1:0] WK = CW'(BASEB << gi);
      assign iready[gi] = rst && (state_reg == RUN) &&
                          (cnt_reg + WK <= CW'(BUFB)) &&
                          (!any_valid || (sel == SELW'(gi)));
    end
  endgenerate

  assign w_sel   = CW'(BASEB) << sel;
  assign in_fire = any_valid && iready[sel];

  // A beat is offered once a full beat is buffered, or during a flush while
  // anything remains.
  assign ovalid_int = (cnt_reg >= CW'(OBYTES)) ||
                      ((state_reg == FLUSH) && (cnt_reg != '0));
  assign ovalid     = rst && ovalid_int;
  assign obytes_int = (cnt_reg >= CW'(OBYTES)) ? OBW'(OBYTES) : OBW'(cnt_reg);
  assign obytes     = ovalid ? obytes_int : '0;
  assign out_fire   = ovalid && oready;
  assign drained    = out_fire ? CW'(obytes) : '0;

  // New data is appended after the data that survives this cycle's drain.
  assign base     = cnt_reg - drained;
  assign cnt_next = base + (in_fire ? w_sel : '0);

  // Per buffer byte: shift down by the drained amount, then overlay the
  // incoming write. Bytes above cnt are always zero, so a shift never
  // exposes stale data.
  generate
    for (gi = 0; gi < BUFB; gi++) begin : g_byte
      localparam logic [CW-1:0] GI = CW'(gi);
      logic [CW-1:0] src;
      logic [7:0]    shifted;
      logic [7:0]    byte_nxt;

      assign src     = GI + drained;
      assign shifted = (src < CW'(BUFB)) ? buf_reg[src[AW-1:0]] : 8'h00;

      always_comb begin
        byte_nxt = shifted;
        if (in_fire && (GI >= base) && (GI < base + w_sel)) begin
          byte_nxt = idata[IW'(GI - base)];
        end
      end

      assign buf_next[gi] = byte_nxt;
    end
  endgenerate

  // Bytes beyond the valid count are forced to zero (zero padding).
  generate
    for (gi = 0; gi < OBYTES; gi++) begin : g_out
      assign odata[gi] = (CW'(gi) < CW'(obytes)) ? buf_reg[gi] : 8'h00;
    end
  endgenerate

  // Flush sequencing.
  always_comb begin
    state_next = state_reg;
    fready     = 1'b0;
    fdone      = 1'b0;
    case (state_reg)
      RUN: begin
        fready = 1'b1;
        if (flush) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        // This also covers an empty buffer on entry: go straight to DONE.
        if (cnt_next == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        fdone      = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      buf_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      buf_reg   <= buf_next;
    end
  end

endmodule

// File: tb/tb_streamwriter.sv
// Bench for streamwriter. A byte-queue model tracks the expected buffer
// contents and flush phase. It is compared against every DUT output on each
// falling edge. Directed steps also check hand-computed literal values.
module tb_streamwriter;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           ivalid;
  logic [3:0]           iready;
  logic [63:0][7:0]     idata;
  logic                 flush;
  logic                 fready;
  logic                 fdone;
  logic                 ovalid;
  logic                 oready;
  logic [63:0][7:0]     odata;
  logic [6:0]           obytes;

  int checks = 0;
  int errors = 0;

  // Model: bytes buffered, oldest first; phase 0=run, 1=flushing, 2=done.
  byte unsigned mq[$];
  int           phase = 0;

  streamwriter #(
    .IOPT(4), .BASEB(8), .IBYTES(64), .OBYTES(64), .BUFB(128)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ivalid (ivalid),
    .iready (iready),
    .idata  (idata),
    .flush  (flush),
    .fready (fready),
    .fdone  (fdone),
    .ovalid (ovalid),
    .oready (oready),
    .odata  (odata),
    .obytes (obytes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle model compare, followed by the model update for the coming edge.
  always @(negedge clk) begin : model
    int               sz;
    int               sel;
    int               ob;
    logic [3:0]       eir;
    logic             eov;
    logic [63:0][7:0] eod;

    sz  = mq.size();
    sel = -1;
    for (int k = 3; k >= 0; k--) if (ivalid[k]) sel = k;
    for (int k = 0; k < 4; k++)
      eir[k] = rst && (phase == 0) && (sz + (8 << k) <= 128) && (sel < 0 || sel == k);
    eov = rst && (sz >= 64 || (phase == 1 && sz > 0));
    ob  = eov ? ((sz < 64) ? sz : 64) : 0;
    for (int j = 0; j < 64; j++) eod[j] = (j < ob) ? mq[j] : 8'h00;

    chk("m_iready", iready, eir);
    chk("m_ovalid", ovalid, eov);
    chk("m_obytes", obytes, ob);
    chk("m_fready", fready, phase == 0);
    chk("m_fdone",  fdone,  phase == 2);
    checks++;
    if (odata !== eod) begin
      errors++;
      $display("FAIL m_odata: got %h expected %h", odata, eod);
    end

    if (!rst) begin
      mq.delete();
      phase = 0;
    end else begin
      if (eov && oready) repeat (ob) void'(mq.pop_front());
      if (sel >= 0 && eir[sel]) for (int j = 0; j < (8 << sel); j++) mq.push_back(idata[j]);
      case (phase)
        0: if (flush) phase = 1;
        1: if (mq.size() == 0) phase = 2;
        default: phase = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pat(input int b);
    for (int i = 0; i < 64; i++) idata[i] = 8'(b + i);
  endtask

  initial begin
    rst = 1'b0; ivalid = 4'b0010; oready = 1'b0; flush = 1'b0; pat(0);

    // Reset held for two edges.
    step;
    @(negedge clk); chk("rst_iready", iready, 0); chk("rst_ovalid", ovalid, 0);
    step;
    @(negedge clk); chk("rst_iready2", iready, 0); chk("rst_ovalid2", ovalid, 0);
    step;
    rst = 1'b1; ivalid = 4'b0000;
    @(negedge clk);
    chk("post_ovalid", ovalid, 0); chk("post_obytes", obytes, 0);
    chk("post_fready", fready, 1); chk("post_fdone", fdone, 0);
    chk("post_iready", iready, 4'hf);

    // Pack: four 16-byte writes make one beat.
    step;
    oready = 1'b1; ivalid = 4'b0010; pat(0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk); chk("pack_pre_ovalid", ovalid, 0); chk("pack_iready", iready, 4'b0010);
      step;
    end
    ivalid = 4'b0000;
    @(negedge clk);
    chk("pack_ovalid", ovalid, 1); chk("pack_obytes", obytes, 64);
    chk("pack_od0", odata[0], 0); chk("pack_od15", odata[15], 15);
    chk("pack_od16", odata[16], 0); chk("pack_od37", odata[37], 5);
    chk("pack_od63", odata[63], 15);
    step;
    @(negedge clk); chk("pack_drained", ovalid, 0);

    // Backpressure: fill to 128 with 64-byte writes.
    step;
    oready = 1'b0; ivalid = 4'b1000; pat(64);
    @(negedge clk); chk("bp_ir_a", iready, 4'b1000);
    step;
    pat(128);
    @(negedge clk); chk("bp_ir_b", iready, 4'b1000); chk("bp_ov_b", ovalid, 1);
    step;
    ivalid = 4'b0001;
    @(negedge clk); chk("bp_full_ir0", iready, 0); chk("bp_full_ob", obytes, 64);
    step;
    ivalid = 4'b1000; oready = 1'b1;
    @(negedge clk); chk("bp_no_comb", iready, 0); chk("bp_od0", odata[0], 64);
    step;
    @(negedge clk); chk("bp_ir_after", iready, 4'b1000); chk("bp_od0_b", odata[0], 128);
    step;
    ivalid = 4'b0000;
    @(negedge clk); chk("bp_ov_c", ovalid, 1); chk("bp_od63_c", odata[63], 191);
    step;
    @(negedge clk); chk("bp_empty", ovalid, 0);

    // Simultaneous drain and append, then flush the 32 leftover bytes.
    step;
    oready = 1'b0; ivalid = 4'b1000; pat(8'h40);
    step;
    oready = 1'b1; ivalid = 4'b0100; pat(0);
    @(negedge clk); chk("sim_ov", ovalid, 1); chk("sim_ir", iready, 4'b0100);
    chk("sim_od0", odata[0], 8'h40);
    step;
    ivalid = 4'b0000;
    @(negedge clk); chk("sim_ov_after", ovalid, 0); chk("sim_ob_after", obytes, 0);
    step;
    flush = 1'b1;
    @(negedge clk); chk("sim_fready", fready, 1);
    step;
    flush = 1'b0; oready = 1'b0;
    @(negedge clk);
    chk("sim_fl_ob", obytes, 32); chk("sim_fl_od0", odata[0], 0);
    chk("sim_fl_od31", odata[31], 31); chk("sim_fl_od32", odata[32], 0);
    chk("sim_fl_fready", fready, 0);
    step;
    oready = 1'b1;
    @(negedge clk); chk("sim_fl_stable", obytes, 32);
    step;
    @(negedge clk); chk("sim_fdone", fdone, 1); chk("sim_done_ov", ovalid, 0);
    step;
    @(negedge clk); chk("sim_fdone_end", fdone, 0);

    // Flush partial: three 8-byte writes, then flush.
    step;
    oready = 1'b0; ivalid = 4'b0001; pat(8'hA0);
    step;
    pat(8'hB0);
    step;
    pat(8'hC0);
    step;
    ivalid = 4'b0000; flush = 1'b1;
    @(negedge clk); chk("fp_ov_pre", ovalid, 0);
    step;
    flush = 1'b0; ivalid = 4'b0001;
    @(negedge clk);
    chk("fp_ov", ovalid, 1); chk("fp_ob", obytes, 24);
    chk("fp_od0", odata[0], 8'hA0); chk("fp_od8", odata[8], 8'hB0);
    chk("fp_od23", odata[23], 8'hC7); chk("fp_od24", odata[24], 0);
    chk("fp_od63", odata[63], 0); chk("fp_ir", iready, 0);
    step;
    oready = 1'b1;
    @(negedge clk); chk("fp_hold_ob", obytes, 24); chk("fp_hold_ir", iready, 0);
    step;
    oready = 1'b0;
    @(negedge clk); chk("fp_fdone", fdone, 1); chk("fp_done_ir", iready, 0);
    step;
    ivalid = 4'b0000;
    @(negedge clk); chk("fp_fdone_end", fdone, 0); chk("fp_run_ir", iready, 4'hf);

    // Full blocks larger options only: fill to 120 bytes.
    step;
    ivalid = 4'b1000; pat(1);
    step;
    ivalid = 4'b0100; pat(2);
    step;
    ivalid = 4'b0010; pat(3);
    step;
    ivalid = 4'b0001; pat(4);
    step;
    ivalid = 4'b0010;
    @(negedge clk); chk("full_ir16", iready, 0);
    step;
    ivalid = 4'b0001; pat(5);
    @(negedge clk); chk("full_ir8", iready, 4'b0001);
    step;
    ivalid = 4'b0000;
    @(negedge clk); chk("full_ir_none", iready, 0); chk("full_od0", odata[0], 1);
    step;
    oready = 1'b1;
    step;
    @(negedge clk);
    chk("full_b2_od0", odata[0], 2); chk("full_b2_od32", odata[32], 3);
    chk("full_b2_od48", odata[48], 4); chk("full_b2_od56", odata[56], 5);
    step;
    @(negedge clk); chk("full_empty", ovalid, 0);

    // Multi-select, flush with data, then flush on empty buffer.
    step;
    oready = 1'b0; ivalid = 4'b1010; pat(8'h10);
    @(negedge clk); chk("ms_ir", iready, 4'b0010);
    step;
    ivalid = 4'b0000; flush = 1'b1;
    step;
    flush = 1'b0; oready = 1'b1;
    @(negedge clk); chk("ms_ob", obytes, 16); chk("ms_od15", odata[15], 8'h1F);
    step;
    @(negedge clk); chk("ms_fdone", fdone, 1);
    step;
    flush = 1'b1;
    @(negedge clk); chk("ef_fready", fready, 1);
    step;
    flush = 1'b0;
    @(negedge clk); chk("ef_ov", ovalid, 0); chk("ef_fdone_early", fdone, 0);
    step;
    @(negedge clk); chk("ef_fdone", fdone, 1); chk("ef_ov2", ovalid, 0);
    step;
    @(negedge clk); chk("ef_fdone_end", fdone, 0);

    // Reset mid-operation discards a buffered full beat.
    step;
    oready = 1'b0; ivalid = 4'b1000; pat(7);
    step;
    ivalid = 4'b0000; rst = 1'b0;
    @(negedge clk); chk("mr_ov_in_rst", ovalid, 0); chk("mr_ir_in_rst", iready, 0);
    step;
    rst = 1'b1;
    @(negedge clk); chk("mr_ov", ovalid, 0); chk("mr_ob", obytes, 0);
    chk("mr_ir", iready, 4'hf);
    step;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/streamwriter.md
Name: streamwriter

Overview:
- Write-side counterpart of streambuffer: accepts variable-width element writes on one of IOPT option ports and packs them, byte-contiguous, into fixed OBYTES-wide beats for the memory/storage write path.
- Where streambuffer unpacks fixed-width input into variable-width outputs, streamwriter packs variable-width inputs into fixed-width output beats.
- A flush request drains a trailing partial beat, zero-padded, with a valid-byte count.

Parameters:
- IOPT, 4, number of input width options; option k carries W_k = BASEB << k bytes.
- BASEB, 8, byte width of option 0 (widths 8/16/32/64).
- IBYTES, 64, input data bus bytes; must equal BASEB << (IOPT-1).
- OBYTES, 64, output beat bytes; must be ≥ IBYTES.
- BUFB, 2*OBYTES, internal packing buffer bytes.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-low: state cleared on a rising clk edge while rst==0.
- ivalid  in  [IOPT] x 1  per-option write valid.
- iready  out  [IOPT] x 1  per-option write accept.
- idata  in  byte_t[IBYTES]  write data; option k uses idata[0..W_k-1], rest ignored.
- flush  in  1  request drain of partial data (level; sampled when fready==1).
- fready  out  1  flush accepted this cycle.
- fdone  out  1  one-cycle pulse: flush complete, buffer empty.
- ovalid  out  1  output beat valid.
- oready  in  1  downstream accepts beat.
- odata  out  byte_t[OBYTES]  beat data; byte 0 = oldest.
- obytes  out  $clog2(OBYTES+1)  valid bytes in beat (OBYTES except final flush beat).

Behaviour:
- State: buf byte_t[BUFB], cnt in 0..BUFB, FSM {RUN, FLUSH, DONE}.
- Reset (rst==0 at edge): cnt=0, buf all 0, state RUN.
  - Outputs after reset: ovalid=0, obytes=0, odata all 0, iready all 0 only if BUFB<W_k (never at defaults; otherwise 1), fready=1, fdone=0.
- Input selection: sel = lowest k with ivalid[k]==1.
  - iready[k]=1 only for k==sel, state==RUN, and cnt+W_k ≤ BUFB (uses current cnt, not drain). Other bits 0.
  - With no ivalid asserted: iready[k] = (state==RUN && cnt+W_k ≤ BUFB).
  - No combinational path from oready to iready.
- Input fire: ivalid[k]&&iready[k]. Write idata[0..W_k-1] to buf[base..base+W_k-1], where base = cnt − drained.
- Output: ovalid = (cnt ≥ OBYTES) || (state==FLUSH && cnt>0).
  - odata = buf[0..OBYTES-1] with bytes ≥ obytes forced to 0.
  - obytes = min(cnt, OBYTES) when ovalid, else 0.
  - ovalid/odata are stable until fire (no retraction without oready).
- Output fire: ovalid&&oready. drained = obytes; buf shifts down by drained; vacated top bytes become 0.
- Simultaneous input and output fire: cnt_next = cnt − drained + W_k. Append lands after the shifted data; latency input→appearing in odata = 1 cycle.
- FSM:
  - RUN: fready=1. flush==1 → FLUSH (same edge; an input fire in that cycle is still accepted and included).
  - FLUSH: fready=0, iready all 0. Emits full beats, then one partial beat if cnt%OBYTES≠0. cnt_next==0 → DONE.
  - FLUSH with cnt==0 on entry → DONE next edge, no beat emitted.
  - DONE: fdone=1 for exactly one cycle, iready all 0, ovalid=0 → RUN.
- flush held high in DONE is ignored; re-sampled in RUN (second flush on empty buffer → FLUSH→DONE, fdone pulse, no beat).
- Full: cnt+W_k > BUFB blocks option k only; smaller options may still be accepted.
- Reset mid-operation: all buffered data discarded, no beat emitted, FSM to RUN.
- Data order preserved byte-exactly across options; no gaps between writes.

Test Plan:
- Reset: rst=0 two cycles with ivalid=4'b0010 → iready all 0 and ovalid=0 during reset. After release: ovalid=0, obytes=0, fready=1, cnt=0.
- Pack: idata[i]=i; option1 (16B) fired 4 times, oready=1 → one beat, ovalid 1 cycle after 4th fire, odata[j]=j%16, obytes=64.
- Backpressure: oready=0, option3 (64B) fired continuously → 2 accepts (cnt=128), then iready[3]=0 and iready[0]=0. Set oready=1 → beat out and iready[3]=1 same cycle as drain visible (next edge).
- Simultaneous: cnt=64, oready=1 and option2 (32B) fire in same cycle → beat drained, cnt=32, next odata[0..31]=0..31 and obytes stays 0 until flush.
- Flush partial: option0 (8B) ×3 then flush → beat obytes=24, odata[24..63]=0, then fdone pulse exactly one cycle. iready all 0 throughout FLUSH/DONE.
- Multi-select and empty flush: ivalid=4'b1010 → only iready[1]=1, 16 bytes appended. Flush on empty buffer → no ovalid, fdone 2 cycles after flush sampled.
